bcd_seq_converter: RTL and testbench

//  Multi-cycle parametrised binary-to-BCD converter (shift-add-3 / double dabble), one iteration per clock.

---
 rtl/bcd_seq_converter_pkg.sv | 30 +++
 rtl/bcd_seq_converter_if.sv | 29 ++
 rtl/bcd_seq_converter_add3_digit.sv | 11 +
 rtl/bcd_seq_converter.sv | 121 ++++++++++++
 tb/tb_bcd_seq_converter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/bcd_seq_converter_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Optional leading-zero blanking is selected with BCD_BLANK_LEADING_EN.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;

    // Smallest digit count d with 10^d > 2^w-1; bounded loop keeps it a constant function.
    function automatic int bcd_digits(input int w);
        longint unsigned maxv;
        longint unsigned pow10;
        int d;
        maxv  = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        pow10 = 64'd1;
        d     = 0;
        for (int i = 0; i < 20; i++) begin
            if (pow10 <= maxv) begin
                pow10 = pow10 * 64'd10;
                d     = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_seq_converter_if.sv
// Request/result bundle between a counter source and the BCD converter.
// Macro BCD_BLANK_LEADING_EN (optional) controls whether blank carries data.
interface bcd_seq_converter_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    import bcd_pkg::*;

    // start is sampled only while idle (or in the done cycle); bin_in is captured on that
    // accepting edge. busy is high while iterating; done pulses one cycle when bcd_out/blank update.
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [DIGITS-1:0]     blank;
    state_t                dbg_state;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, blank, dbg_state
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, blank, dbg_state
    );

endinterface

// File: rtl/bcd_seq_converter_add3_digit.sv
// One double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
module bcd_add3_digit
    import bcd_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= BCD_ADD3_THRESH) ? (d + 4'd3) : d;

endmodule

// File: rtl/bcd_seq_converter.sv
// Multi-cycle binary-to-BCD converter, one shift-add-3 iteration per clock.
// Define BCD_BLANK_LEADING_EN to register a leading-zero blank mask alongside bcd_out.
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    bcd_seq_converter_if.slave bus
);

    localparam int CW    = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;

    if (BIN_W < 1) begin : g_bin_w_check
        $error("bcd_seq_converter: BIN_W must be at least 1");
    end
    if (DIGITS < bcd_digits(BIN_W)) begin : g_digits_check
        $error("bcd_seq_converter: DIGITS too small for BIN_W");
    end

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [SR_W-1:0]    shreg;
    logic [BCD_W-1:0]   adj_digits;
    logic [SR_W-1:0]    shifted;
    logic [BCD_W-1:0]   bcd_next;
    logic [BCD_W-1:0]   bcd_r;
    logic               busy_r;
    logic               done_r;
    logic               last_iter;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .d (shreg[BIN_W + 4*g +: 4]),
            .q (adj_digits[4*g +: 4])
        );
    end

    assign shifted   = {adj_digits, shreg[BIN_W-1:0]} << 1;
    assign bcd_next  = shifted[SR_W-1 -: BCD_W];
    assign last_iter = (state == SHIFT) && (cnt == CW'(1));

    // DONE behaves like IDLE for start so back-to-back conversions leave no gap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            shreg  <= '0;
            bcd_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        shreg  <= {{BCD_W{1'b0}}, bus.bin_in};
                        cnt    <= CW'(BIN_W);
                        busy_r <= 1'b1;
                        state  <= SHIFT;
                    end else begin
                        state  <= IDLE;
                    end
                end
                SHIFT: begin
                    shreg <= shifted;
                    cnt   <= cnt - CW'(1);
                    if (last_iter) begin
                        bcd_r  <= bcd_next;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef BCD_BLANK_LEADING_EN
    logic [DIGITS-1:0] blank_next;
    logic [DIGITS-1:0] blank_r;

    // Walk down from the top digit; a digit blanks only while everything above it is zero.
    always_comb begin
        logic zero_above;
        blank_next = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above    = zero_above && (bcd_next[4*i +: 4] == 4'd0);
            blank_next[i] = zero_above;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blank_r <= '0;
        end else if (last_iter) begin
            blank_r <= blank_next;
        end
    end

    assign bus.blank = blank_r;
`else
    assign bus.blank = '0;
`endif

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.bcd_out   = bcd_r;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed bench for bcd_seq_converter at BIN_W=8, DIGITS=3, including an exhaustive sweep.
// Blank expectations follow BCD_BLANK_LEADING_EN as compiled.
module tb_bcd_seq_converter;
    import bcd_pkg::*;

    localparam int BIN_W  = 8;
    localparam int DIGITS = 3;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic [11:0] exp_q[$];

    bcd_seq_converter_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bcd_seq_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] model_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    function automatic logic [2:0] model_blank(input logic [11:0] b);
`ifdef BCD_BLANK_LEADING_EN
        logic [2:0] m;
        m    = 3'b000;
        m[2] = (b[11:8] == 4'd0);
        m[1] = m[2] && (b[7:4] == 4'd0);
        return m;
`else
        return (b == 12'hfff) ? 3'b111 : 3'b000;
`endif
    endfunction

    // Waits for done with a cycle bound; returns cycles waited.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = bus.busy ? 1 : 0;
        while (!bus.done && lat < 40) begin
            step();
            lat++;
            if (bus.busy) bcnt++;
        end
        if (lat >= 40) check("done_timeout", 32'(lat), 32'd8);
    endtask

    task automatic score(input string tag);
        logic [11:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_bcd"}, 32'(bus.bcd_out), 32'(e));
            check({tag, "_blank"}, 32'(bus.blank), 32'(model_blank(e)));
        end
    endtask

    task automatic run_conv(input int v, input string tag);
        int lat, bcnt;
        exp_q.push_back(model_bcd(v));
        bus.start  = 1'b1;
        bus.bin_in = 8'(v);
        step();
        bus.start  = 1'b0;
        bus.bin_in = 8'($urandom_range(0, 255));
        wait_done(lat, bcnt);
        check({tag, "_latency"}, 32'(lat), 32'd8);
        check({tag, "_busy_cycles"}, 32'(bcnt), 32'd8);
        score(tag);
        step();
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int lat, bcnt, dcnt;
        logic [11:0] cap;
        errors     = 0;
        checks     = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        step();
        step();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_bcd", 32'(bus.bcd_out), 32'd0);
        check("rst_blank", 32'(bus.blank), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        step();

        run_conv(255, "v255");
        check("v255_hex", 32'(bus.bcd_out), 32'h255);
        run_conv(0, "v0");
        check("v0_hex", 32'(bus.bcd_out), 32'h000);
`ifdef BCD_BLANK_LEADING_EN
        check("v0_blank_hand", 32'(bus.blank), 32'b110);
`endif
        run_conv(7, "v7");
        check("v7_hex", 32'(bus.bcd_out), 32'h007);
`ifdef BCD_BLANK_LEADING_EN
        check("v7_blank_hand", 32'(bus.blank), 32'b110);
`endif

        // start hammered while busy: only 123 converts, one done
        bus.start  = 1'b1;
        bus.bin_in = 8'd123;
        step();
        check("ign_state", 32'(bus.dbg_state), 32'(SHIFT));
        for (int i = 0; i < 7; i++) begin
            bus.bin_in = 8'($urandom_range(0, 255));
            step();
        end
        bus.start = 1'b0;
        dcnt = 0;
        cap  = '0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.done) begin
                dcnt++;
                cap = bus.bcd_out;
            end
        end
        check("ign_done_count", 32'(dcnt), 32'd1);
        check("ign_bcd", 32'(cap), 32'h123);

        // reset during iteration 4 of converting 200
        bus.start  = 1'b1;
        bus.bin_in = 8'd200;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        check("midrst_bcd", 32'(bus.bcd_out), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        dcnt  = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.done) dcnt++;
        end
        check("midrst_no_done", 32'(dcnt), 32'd0);
        run_conv(99, "v99");
        check("v99_hex", 32'(bus.bcd_out), 32'h099);

        // start held high: 1,2,3 back to back
        bus.start  = 1'b1;
        bus.bin_in = 8'd1;
        exp_q.push_back(12'h001);
        step();
        for (int n = 2; n <= 4; n++) begin
            if (n <= 3) begin
                bus.bin_in = 8'(n);
                exp_q.push_back(model_bcd(n));
            end else begin
                bus.start = 1'b0;
            end
            wait_done(lat, bcnt);
            check($sformatf("cont%0d_latency", n - 1), 32'(lat), 32'd8);
            score($sformatf("cont%0d", n - 1));
            step();
            check($sformatf("cont%0d_next_busy", n - 1), 32'(bus.busy), (n <= 3) ? 32'd1 : 32'd0);
        end

        // exhaustive sweep against the decimal model
        for (int v = 0; v < 256; v++) begin
            run_conv(v, $sformatf("ex%0d", v));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
